// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks an inclusive register address range through one register-file read
// port. Each word is captured and presented as {out_addr, out_data} on a
// valid/ready stream. Ranges wrap modulo 2**ADDR_W, so first > last is
// legal. The block only reads the register file.
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last;
    logic              handshake;
    logic              at_last;

    assign handshake = out_valid & out_ready;
    assign at_last   = (cur == last);

    // cur is itself a register, so the read address is held for the whole READ cycle.
    assign rd_addr = cur;

    // State decode: both flags come straight from the state register.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Next-state selection; abort overrides everything, including start in IDLE.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = READ;
                READ: state_nxt = SEND;
                SEND: if (handshake) state_nxt = at_last ? DONE : READ;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Range walk: latch the range on an accepted start, advance after each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= '0;
            last <= '0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                cur  <= first_addr;
                last <= last_addr;
            end else if (state == SEND && handshake && !at_last) begin
                cur <= cur + ADDR_W'(1);
            end
        end
    end

    // Output valid: raised when a word is captured, dropped on handshake or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else if (state == READ) begin
            out_valid <= 1'b1;
        end else if (state == SEND && handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Word capture: snapshot of the register at the READ cycle, held through SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= '0;
            out_data <= '0;
        end else if (state == READ && !abort) begin
            out_addr <= cur;
            out_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader: directed scenarios plus randomized dumps,
// checked against a range/snapshot model of the expected word stream.
`timescale 1ns/1ps
module tb_regfile_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Register file read port: combinational read.
    assign rd_data = regs[rd_addr];

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one dump. The expected stream is the list of addresses (f+i) mod 32
    // for i in 0..((l-f) mod 32), each paired with the register value at start.
    // n counts cycles after the one in which start was sampled.
    task automatic run_dump(input int f, input int l, input int hold_low, input bit rnd,
                            input int restart_at, input bit poke5,
                            output int n_done, output int vcycles, output int first_v);
        int            exp_a [$];
        logic [DW-1:0] exp_d [$];
        int            cnt;
        int            n;
        int            lowleft;
        bit            rdy;
        bit            have_prev;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        cnt = (((l - f) % 32) + 32) % 32 + 1;
        for (int i = 0; i < cnt; i++) begin
            exp_a.push_back((f + i) % 32);
            exp_d.push_back(regs[(f + i) % 32]);
        end
        @(negedge clk);
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start      = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        n         = 1;
        n_done    = -1;
        vcycles   = 0;
        first_v   = -1;
        have_prev = 1'b0;
        lowleft   = hold_low;
        pa        = '0;
        pd        = '0;
        check("busy_after_start", busy, 1);
        while (n < 400) begin
            if (done) begin
                n_done = n;
                break;
            end
            if (n == restart_at) begin
                start      = 1'b1;
                first_addr = 5'd20;
                last_addr  = 5'd25;
            end else if (n == restart_at + 1) begin
                start = 1'b0;
            end
            if (out_valid) begin
                vcycles++;
                if (first_v < 0) first_v = n;
                if (have_prev) begin
                    check("stable_addr", out_addr, pa);
                    check("stable_data", out_data, pd);
                end
                if (lowleft > 0) begin
                    rdy = 1'b0;
                    lowleft--;
                end else begin
                    rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                out_ready = rdy;
                if (poke5 && !rdy) regs[5] = $urandom;
                if (rdy) begin
                    check("word_available", exp_a.size() > 0, 1);
                    if (exp_a.size() > 0) begin
                        check("word_addr", out_addr, exp_a.pop_front());
                        check("word_data", out_data, exp_d.pop_front());
                    end
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    pa = out_addr;
                    pd = out_data;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                have_prev = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check("done_seen", n_done > 0, 1);
        check("words_left", exp_a.size(), 0);
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nd, vc, fv, f, l, cnt;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: full dump 0..31, reg[i] = i*3
        for (int i = 0; i < 32; i++) regs[i] = DW'(i * 3);
        run_dump(0, 31, 0, 0, -1, 0, nd, vc, fv);
        check("full_start_to_done", nd, 65);
        check("full_first_latency", fv, 2);
        check("full_word_count", vc, 32);

        // 2: wrap range 30,31,0,1
        regs[30] = 32'hAAAA; regs[31] = 32'hBBBB; regs[0] = 32'h0; regs[1] = 32'h1111;
        run_dump(30, 1, 0, 0, -1, 0, nd, vc, fv);
        check("wrap_word_count", vc, 4);
        check("wrap_start_to_done", nd, 9);

        // 3: backpressure on a single word, register rewritten while held
        regs[5] = 32'hDEADBEEF;
        run_dump(5, 5, 4, 0, -1, 1, nd, vc, fv);
        check("bp_valid_cycles", vc, 5);
        check("bp_start_to_done", nd, 7);

        // 4: abort while word 10 is in SEND
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        @(negedge clk);
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && !(out_valid && out_addr == 5'd10); k++) @(negedge clk);
        check("abort_reached_word10", out_valid && out_addr == 5'd10, 1);
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cur_kept", rd_addr, 10);
        for (int k = 0; k < 4; k++) begin
            check("abort_no_done", done, 0);
            check("abort_no_valid", out_valid, 0);
            @(negedge clk);
        end
        run_dump(4, 4, 0, 0, -1, 0, nd, vc, fv);
        check("after_abort_count", vc, 1);
        check("after_abort_done", nd, 3);

        // 5: second start during a 0..3 dump is ignored
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run_dump(0, 3, 0, 0, 3, 0, nd, vc, fv);
        check("busy_start_count", vc, 4);
        check("busy_start_done", nd, 9);

        // 6: reset during a READ cycle
        @(negedge clk);
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_out_addr", out_addr, 0);
        check("midrst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_valid", out_valid, 0);

        // abort beats start in IDLE
        first_addr = 5'd7; last_addr = 5'd9; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_over_start_busy", busy, 0);
        check("abort_over_start_cur", rd_addr, 0);
        @(negedge clk);
        check("abort_over_start_idle", busy, 0);

        // randomized dumps with random backpressure
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            cnt = (((l - f) % 32) + 32) % 32 + 1;
            run_dump(f, l, 0, 1, -1, 0, nd, vc, fv);
            check("rand_min_cycles", nd >= 2 * cnt + 1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
